// File: rtl/spi_flash_pkg.sv
// Purpose: opcodes, FSM state encoding and ID byte helper for the SPI flash emulator.
// Latency: none (declarations only).
// Backpressure: not applicable.
package spi_flash_pkg;

   localparam logic [7:0] OP_READ  = 8'h03;
   localparam logic [7:0] OP_FREAD = 8'h0B;
   localparam logic [7:0] OP_RDID  = 8'h9F;
   localparam logic [7:0] OP_RDSR  = 8'h05;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_ADDR,
      S_DUMMY,
      S_DATA,
      S_ID,
      S_SR,
      S_IGNORE
   } state_t;

   // Select one byte of the 24-bit JEDEC ID, index 0 is the manufacturer byte.
   function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
      case (idx)
         2'd0:    id_byte = id[23:16];
         2'd1:    id_byte = id[15:8];
         default: id_byte = id[7:0];
      endcase
   endfunction

endpackage

// File: rtl/spi_flash_emu_if.sv
// Purpose: SPI pin bundle between a flash master and the emulator.
// Latency: none (wires only).
// Backpressure: none; SPI has no flow control beyond chip select.
interface spi_flash_emu_if;
   logic spi_sck_i;
   logic spi_cs_ni;
   logic spi_mosi_i;
   logic spi_miso_o;
   logic miso_oe_o;

   modport master (
      output spi_sck_i,
      output spi_cs_ni,
      output spi_mosi_i,
      input  spi_miso_o,
      input  miso_oe_o
   );

   modport slave (
      input  spi_sck_i,
      input  spi_cs_ni,
      input  spi_mosi_i,
      output spi_miso_o,
      output miso_oe_o
   );
endinterface

// File: rtl/spi_sync_edge.sv
// Purpose: 2-FF synchroniser for SPI pins, with rise/fall strobes for the clock pin.
// Latency: 2 clk for levels, strobes 1-clk wide valid 2 clk after the pin edge.
// Backpressure: none; strobes are produced every pin edge.
module spi_sync_edge #(
   parameter int W = 2
) (
   input  logic         clk_i,
   input  logic         edge_i,
   input  logic [W-1:0] lvl_i,
   output logic [W-1:0] lvl_o,
   output logic         rise_o,
   output logic         fall_o
);

   logic [W:0] s1;
   logic [W:0] s2;
   logic       s3;

   // Synchroniser chain, deliberately not reset: after a reset the synced
   // levels reflect the real pins, so a chip select held low through reset
   // is never mistaken for a fresh select.
   always_ff @(posedge clk_i) begin
      s1 <= {lvl_i, edge_i};
      s2 <= s1;
      s3 <= s2[0];
   end

   assign lvl_o  = s2[W:1];
   assign rise_o =  s2[0] & ~s3;
   assign fall_o = ~s2[0] &  s3;

endmodule

// File: rtl/spi_flash_emu.sv
// Purpose: mode-0 SPI NOR flash slave (READ, FAST_READ, RDID, RDSR) over on-chip byte memory.
// Latency: pins synced in 2 clk; MISO updates ~4 clk after each SCK fall; byte fetch 1 clk.
// Backpressure: none; master paces via SCK, CS_n high aborts at once, preload never stalls.
module spi_flash_emu
   import spi_flash_pkg::*;
#(
   parameter int          DEPTH    = 1024,
   parameter int          AW       = $clog2(DEPTH),
   parameter int          DUMMY    = 8,
   parameter logic [23:0] JEDEC_ID = 24'hBF2541,
   parameter string       INIT     = ""
) (
   input  logic          clk_i,
   input  logic          rst_i,
   spi_flash_emu_if.slave spi,
   input  logic          ld_we_i,
   input  logic [AW-1:0] ld_addr_i,
   input  logic [7:0]    ld_data_i,
   output logic          busy_o,
   output logic          bad_cmd_o
);

   localparam int DCW = (DUMMY > 0) ? $clog2(DUMMY + 1) : 1;

   logic           cs_s;
   logic           mosi_s;
   logic           sck_rise;
   logic           sck_fall;

   state_t         state;
   logic [4:0]     bit_cnt;
   logic [DCW-1:0] dummy_left;
   logic [2:0]     obit;
   logic [1:0]     id_idx;
   logic [AW-1:0]  addr;
   logic [6:0]     cmd_sr;
   logic [7:0]     cur;
   logic           armed;
   logic           miso_q;
   logic           oe_q;

   logic [7:0]     mem [DEPTH];
   logic [7:0]     rd_data;
   logic           rd_en;
   logic [AW-1:0]  rd_addr;

   logic [7:0]     opcode;
   logic [AW-1:0]  addr_next;
   logic [7:0]     next_byte;

   spi_sync_edge #(.W(2)) u_sync (
      .clk_i  (clk_i),
      .edge_i (spi.spi_sck_i),
      .lvl_i  ({spi.spi_mosi_i, spi.spi_cs_ni}),
      .lvl_o  ({mosi_s, cs_s}),
      .rise_o (sck_rise),
      .fall_o (sck_fall)
   );

   // Opcode and address including the bit arriving on this rising edge; only the
   // low AW address bits survive the shift, which drops the unused upper bits.
   assign opcode    = {cmd_sr, mosi_s};
   assign addr_next = {addr[AW-2:0], mosi_s};

   assign spi.spi_miso_o = miso_q;
   assign spi.miso_oe_o  = oe_q;

   // Byte memory: preload write port and registered read port; a same-cycle
   // read of the address being written returns the old contents.
   always_ff @(posedge clk_i) begin
      if (ld_we_i) mem[ld_addr_i] <= ld_data_i;
      if (rd_en)   rd_data        <= mem[rd_addr];
   end

   // Fetch on DATA entry, then prefetch the following byte while bit1 goes out.
   always_comb begin
      rd_en   = 1'b0;
      rd_addr = addr;
      if (state == S_ADDR && sck_rise && bit_cnt == 5'd23 && dummy_left == '0) begin
         rd_en   = 1'b1;
         rd_addr = addr_next;
      end else if (state == S_DUMMY && sck_rise && dummy_left == DCW'(1)) begin
         rd_en   = 1'b1;
      end else if (state == S_DATA && sck_fall && obit == 3'd6) begin
         rd_en   = 1'b1;
         rd_addr = addr + AW'(1);
      end
   end

   // Source of the byte that starts on the next bit7 fall.
   always_comb begin
      case (state)
         S_DATA:  next_byte = rd_data;
         S_ID:    next_byte = id_byte(JEDEC_ID, id_idx);
         default: next_byte = 8'h00;
      endcase
   end

   // Protocol FSM with registered pin and status outputs.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state      <= S_IDLE;
         bit_cnt    <= '0;
         dummy_left <= '0;
         obit       <= '0;
         id_idx     <= '0;
         addr       <= '0;
         cmd_sr     <= '0;
         cur        <= '0;
         armed      <= 1'b0;
         miso_q     <= 1'b0;
         oe_q       <= 1'b0;
         busy_o     <= 1'b0;
         bad_cmd_o  <= 1'b0;
      end else begin
         bad_cmd_o <= 1'b0;
         // A select only counts once CS_n has been seen high since reset.
         if (cs_s) armed <= 1'b1;

         if (cs_s && state != S_IDLE) begin
            state   <= S_IDLE;
            busy_o  <= 1'b0;
            oe_q    <= 1'b0;
            miso_q  <= 1'b0;
            bit_cnt <= '0;
            obit    <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (!cs_s && armed) begin
                     state   <= S_CMD;
                     busy_o  <= 1'b1;
                     armed   <= 1'b0;
                     bit_cnt <= '0;
                     obit    <= '0;
                     id_idx  <= '0;
                  end
               end
               S_CMD: begin
                  if (sck_rise) begin
                     cmd_sr  <= opcode[6:0];
                     bit_cnt <= bit_cnt + 5'd1;
                     if (bit_cnt == 5'd7) begin
                        bit_cnt    <= '0;
                        dummy_left <= '0;
                        case (opcode)
                           OP_READ:  state <= S_ADDR;
                           OP_FREAD: begin
                              state      <= S_ADDR;
                              dummy_left <= DCW'(DUMMY);
                           end
                           OP_RDID:  state <= S_ID;
                           OP_RDSR:  state <= S_SR;
                           default: begin
                              state     <= S_IGNORE;
                              bad_cmd_o <= 1'b1;
                           end
                        endcase
                     end
                  end
               end
               S_ADDR: begin
                  if (sck_rise) begin
                     addr    <= addr_next;
                     bit_cnt <= bit_cnt + 5'd1;
                     if (bit_cnt == 5'd23) begin
                        bit_cnt <= '0;
                        state   <= (dummy_left != '0) ? S_DUMMY : S_DATA;
                     end
                  end
               end
               S_DUMMY: begin
                  if (sck_rise) begin
                     dummy_left <= dummy_left - DCW'(1);
                     if (dummy_left == DCW'(1)) state <= S_DATA;
                  end
               end
               S_DATA, S_ID, S_SR: begin
                  if (sck_fall) begin
                     oe_q <= 1'b1;
                     obit <= obit + 3'd1;
                     if (obit == 3'd0) begin
                        miso_q <= next_byte[7];
                        cur    <= {next_byte[6:0], 1'b0};
                     end else begin
                        miso_q <= cur[7];
                        cur    <= {cur[6:0], 1'b0};
                     end
                     if (obit == 3'd7) begin
                        if (state == S_DATA) addr <= addr + AW'(1);
                        if (state == S_ID)   id_idx <= (id_idx == 2'd2) ? 2'd0 : id_idx + 2'd1;
                     end
                  end
               end
               default: begin
                  // S_IGNORE: hold MISO released until CS_n goes high.
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_flash_emu.sv
// Purpose: randomized and directed checks of spi_flash_emu against a byte-array flash model.
// Latency: bench drives SCK at clk/10 and samples MISO on its own SCK rise, as a master would.
// Backpressure: expected bytes queue in a scoreboard; the MISO monitor pops them independently.
module tb_spi_flash_emu;

   localparam int          DEPTH = 1024;
   localparam int          AW    = $clog2(DEPTH);
   localparam int          DUMMY = 8;
   localparam logic [23:0] JEDEC = 24'hBF2541;

   localparam logic [7:0] T_READ  = 8'h03;
   localparam logic [7:0] T_FREAD = 8'h0B;
   localparam logic [7:0] T_RDID  = 8'h9F;
   localparam logic [7:0] T_RDSR  = 8'h05;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          sck = 1'b0;
   logic          cs_n = 1'b1;
   logic          mosi = 1'b0;
   logic          ld_we = 1'b0;
   logic [AW-1:0] ld_addr = '0;
   logic [7:0]    ld_data = '0;
   logic          busy;
   logic          bad_cmd;

   int            n_chk = 0;
   int            n_fail = 0;
   int            bad_cnt = 0;
   logic          exp_busy = 1'b0;

   logic [7:0]    mem_model [DEPTH];
   logic [7:0]    sb_q [$];
   logic [7:0]    mbyte = '0;
   int            mbits = 0;

   spi_flash_emu_if spi_if ();
   assign spi_if.spi_sck_i  = sck;
   assign spi_if.spi_cs_ni  = cs_n;
   assign spi_if.spi_mosi_i = mosi;

   spi_flash_emu #(.DEPTH(DEPTH), .DUMMY(DUMMY), .JEDEC_ID(JEDEC)) dut (
      .clk_i     (clk),
      .rst_i     (rst_n),
      .spi       (spi_if),
      .ld_we_i   (ld_we),
      .ld_addr_i (ld_addr),
      .ld_data_i (ld_data),
      .busy_o    (busy),
      .bad_cmd_o (bad_cmd)
   );

   always #10 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic bit op_ok(input logic [7:0] op);
      return op == T_READ || op == T_FREAD || op == T_RDID || op == T_RDSR;
   endfunction

   // Count clk cycles with the bad-command flag high.
   always @(negedge clk) if (bad_cmd) bad_cnt <= bad_cnt + 1;

   // MISO monitor: assembles bytes while the slave drives, pops and compares.
   always @(posedge sck or posedge cs_n) begin
      if (cs_n) begin
         mbits = 0;
      end else begin
         check("busy", {31'd0, busy}, {31'd0, exp_busy});
         if (!spi_if.miso_oe_o) begin
            check("miso_idle", {31'd0, spi_if.spi_miso_o}, 32'd0);
         end else begin
            mbyte = {mbyte[6:0], spi_if.spi_miso_o};
            mbits++;
            if (mbits == 8) begin
               mbits = 0;
               if (sb_q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL miso_unexpected: got 0x%0h, expected no byte", mbyte);
               end else begin
                  check("miso_byte", {24'd0, mbyte}, {24'd0, sb_q.pop_front()});
               end
            end
         end
      end
   end

   initial begin
      #4000000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog");
   end

   task automatic preload(input int a, input logic [7:0] d);
      @(negedge clk);
      ld_we   = 1'b1;
      ld_addr = AW'(a);
      ld_data = d;
      mem_model[a] = d;
      @(negedge clk);
      ld_we   = 1'b0;
   endtask

   task automatic sck_bit(input logic b, input logic chk_oe_low);
      mosi = b;
      repeat (5) @(negedge clk);
      sck = 1'b1;
      if (chk_oe_low) check("oe_low", {31'd0, spi_if.miso_oe_o}, 32'd0);
      repeat (5) @(negedge clk);
      sck = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) sck_bit(b[i], 1'b1);
   endtask

   task automatic begin_txn();
      @(negedge clk);
      exp_busy = 1'b1;
      cs_n     = 1'b0;
   endtask

   task automatic end_txn();
      repeat (5) @(negedge clk);
      cs_n     = 1'b1;
      exp_busy = 1'b0;
      repeat (10) @(negedge clk);
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_oe", {31'd0, spi_if.miso_oe_o}, 32'd0);
   endtask

   task automatic do_txn(input logic [7:0] op, input int a, input int n);
      int   bc0;
      logic bad;
      bc0 = bad_cnt;
      bad = !op_ok(op);
      begin_txn();
      send_byte(op);
      if (op == T_READ || op == T_FREAD) begin
         for (int i = 23; i >= 0; i--) sck_bit(a[i], 1'b1);
         if (op == T_FREAD) repeat (DUMMY) sck_bit(1'($urandom), 1'b1);
      end
      for (int i = 0; i < n; i++) begin
         if (op == T_READ || op == T_FREAD) sb_q.push_back(mem_model[((a % DEPTH) + i) % DEPTH]);
         else if (op == T_RDID)            sb_q.push_back(8'(JEDEC >> (16 - 8 * (i % 3))));
         else if (op == T_RDSR)            sb_q.push_back(8'h00);
      end
      for (int i = 0; i < 8 * n; i++) sck_bit(1'($urandom), bad);
      end_txn();
      check("bad_cmd_pulses", bc0 >= 0 ? bad_cnt - bc0 : 0, bad ? 1 : 0);
   endtask

   initial begin
      logic [7:0] op;
      int         a;

      repeat (5) @(negedge clk);
      check("rst_miso", {31'd0, spi_if.spi_miso_o}, 32'd0);
      check("rst_oe", {31'd0, spi_if.miso_oe_o}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_bad", {31'd0, bad_cmd}, 32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      for (int i = 0; i < DEPTH; i++) preload(i, 8'($urandom));
      preload(0, 8'h11);
      preload(1, 8'h22);
      preload(2, 8'h33);
      preload(3, 8'h44);
      preload(DEPTH - 1, 8'hA5);

      do_txn(T_READ, 0, 4);
      do_txn(T_FREAD, 2, 2);
      do_txn(T_READ, DEPTH - 1, 2);
      do_txn(T_RDID, 0, 4);
      do_txn(T_RDSR, 0, 1);
      do_txn(8'h02, 0, 2);

      // Abort after half the address, then a clean read.
      begin_txn();
      send_byte(T_READ);
      repeat (12) sck_bit(1'($urandom), 1'b1);
      end_txn();
      do_txn(T_READ, 1, 1);

      // Reset in the middle of a data byte with CS_n still low.
      begin_txn();
      send_byte(T_READ);
      for (int i = 0; i < 24; i++) sck_bit(1'b0, 1'b1);
      repeat (3) sck_bit(1'b0, 1'b0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("midrst_miso", {31'd0, spi_if.spi_miso_o}, 32'd0);
      check("midrst_oe", {31'd0, spi_if.miso_oe_o}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_bad", {31'd0, bad_cmd}, 32'd0);
      rst_n    = 1'b1;
      exp_busy = 1'b0;
      repeat (8) sck_bit(1'($urandom), 1'b1);
      end_txn();
      do_txn(T_READ, 0, 2);

      for (int t = 0; t < 16; t++) begin
         repeat ($urandom_range(0, 3)) preload(int'($urandom_range(0, DEPTH - 1)), 8'($urandom));
         a = int'($urandom_range(0, 24'hFFFFFF));
         if ($urandom_range(0, 2) == 0) a = (a & ~(DEPTH - 1)) | (DEPTH - 1 - int'($urandom_range(0, 3)));
         case ($urandom_range(0, 4))
            0: op = T_READ;
            1: op = T_FREAD;
            2: op = T_RDID;
            3: op = T_RDSR;
            default: begin
               do op = 8'($urandom); while (op_ok(op));
            end
         endcase
         do_txn(op, a, int'($urandom_range(1, 5)));
      end

      check("sb_empty", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
